// File: rtl/noc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_sched_pkg
// Description : Shared state encoding and width constants for the NoC schedulers.
// Revision    : 1.0
// ============================================================================
package noc_sched_pkg;

    localparam int c_LEN_WIDTH     = 8;
    localparam int c_DEFICIT_WIDTH = c_LEN_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/drr_packet_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : drr_packet_scheduler_if
// Description : Request/grant bundle between the input channels and the DRR scheduler.
// Revision    : 1.0
// ============================================================================
interface drr_packet_scheduler_if #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int LEN_WIDTH            = 8,
    parameter int QUANTUM_WIDTH        = 8
);
    logic [CHANNEL_NUMBER-1:0]                    req_valid;
    logic [CHANNEL_NUMBER-1:0][LEN_WIDTH-1:0]     pkt_len;
    logic [CHANNEL_NUMBER-1:0][QUANTUM_WIDTH-1:0] quantum;
    logic                                         beat_accept;
    logic                                         grant_valid;
    logic [CHANNEL_NUMBER_WIDTH-1:0]              grant_idx;
    logic [LEN_WIDTH-1:0]                         beats_left;

    modport master (
        output req_valid, pkt_len, quantum, beat_accept,
        input  grant_valid, grant_idx, beats_left
    );

    modport slave (
        input  req_valid, pkt_len, quantum, beat_accept,
        output grant_valid, grant_idx, beats_left
    );
endinterface
`default_nettype wire

// File: rtl/rr_next_finder.sv
`default_nettype none
// ============================================================================
// Module      : rr_next_finder
// Description : Finds the first set request after a start index, wrapping, start last.
// Revision    : 1.0
// ============================================================================
module rr_next_finder #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
    input  wire [CHANNEL_NUMBER-1:0]       i_req,
    input  wire [CHANNEL_NUMBER_WIDTH-1:0] i_start,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] o_next,
    output logic                            o_found
);

    logic [CHANNEL_NUMBER_WIDTH-1:0] w_idx;

    // Walk from the farthest offset down so the nearest hit is the last writer.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
            w_idx = CHANNEL_NUMBER_WIDTH'((int'(i_start) + k) % CHANNEL_NUMBER);
            if (i_req[w_idx]) begin
                o_next  = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/drr_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : drr_packet_scheduler
// Description : Deficit round-robin packet scheduler granting whole packets per channel.
// Revision    : 1.0
// ============================================================================
module drr_packet_scheduler
    import noc_sched_pkg::*;
#(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int LEN_WIDTH            = c_LEN_WIDTH,
    parameter int QUANTUM_WIDTH        = 8,
    parameter int DEFICIT_WIDTH        = LEN_WIDTH + 1
) (
    input wire clk,
    input wire rst_n,
    drr_packet_scheduler_if.slave bus
);

    localparam int c_SUM_WIDTH =
        ((DEFICIT_WIDTH > QUANTUM_WIDTH) ? DEFICIT_WIDTH : QUANTUM_WIDTH) + 1;

    sched_state_t                                  r_state, w_state;
    logic [CHANNEL_NUMBER_WIDTH-1:0]               r_ptr, w_ptr;
    logic [CHANNEL_NUMBER_WIDTH-1:0]               r_grant_idx, w_grant_idx;
    logic                                          r_fresh, w_fresh;
    logic                                          r_grant_valid, w_grant_valid;
    logic [LEN_WIDTH-1:0]                          r_beats_left, w_beats_left;
    logic [CHANNEL_NUMBER-1:0][DEFICIT_WIDTH-1:0]  r_deficit, w_deficit;

    logic [CHANNEL_NUMBER_WIDTH-1:0] w_next_ptr;
    logic                            w_found;
    logic                            w_req_at_ptr;
    logic [LEN_WIDTH-1:0]            w_eff_len;
    logic [QUANTUM_WIDTH-1:0]        w_eff_quantum;
    logic [DEFICIT_WIDTH-1:0]        w_cur_deficit;
    logic [DEFICIT_WIDTH-1:0]        w_len_ext;
    logic [c_SUM_WIDTH-1:0]          w_sum;
    logic [DEFICIT_WIDTH-1:0]        w_sat_sum;

    rr_next_finder #(
        .CHANNEL_NUMBER       (CHANNEL_NUMBER),
        .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH)
    ) u_finder (
        .i_req   (bus.req_valid),
        .i_start (r_ptr),
        .o_next  (w_next_ptr),
        .o_found (w_found)
    );

    // Zero length or zero quantum is promoted to one so every channel makes progress.
    always_comb begin
        w_req_at_ptr  = bus.req_valid[r_ptr];
        w_eff_len     = (bus.pkt_len[r_ptr] == '0) ? LEN_WIDTH'(1) : bus.pkt_len[r_ptr];
        w_eff_quantum = (bus.quantum[r_ptr] == '0) ? QUANTUM_WIDTH'(1) : bus.quantum[r_ptr];
        w_cur_deficit = r_deficit[r_ptr];
        w_len_ext     = DEFICIT_WIDTH'(w_eff_len);
        w_sum         = c_SUM_WIDTH'(w_cur_deficit) + c_SUM_WIDTH'(w_eff_quantum);
        w_sat_sum     = (w_sum > c_SUM_WIDTH'({DEFICIT_WIDTH{1'b1}})) ?
                        {DEFICIT_WIDTH{1'b1}} : w_sum[DEFICIT_WIDTH-1:0];
    end

    always_comb begin
        w_state       = r_state;
        w_ptr         = r_ptr;
        w_fresh       = r_fresh;
        w_deficit     = r_deficit;
        w_beats_left  = r_beats_left;
        w_grant_valid = r_grant_valid;
        w_grant_idx   = r_grant_idx;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    if (!w_req_at_ptr) begin
                        w_deficit[r_ptr] = '0;
                        if (w_found) w_ptr = w_next_ptr;
                        w_fresh = 1'b1;
                    end else if (r_fresh) begin
                        w_deficit[r_ptr] = w_sat_sum;
                        w_fresh = 1'b0;
                    end else if (w_cur_deficit >= w_len_ext) begin
                        w_deficit[r_ptr] = w_cur_deficit - w_len_ext;
                        w_beats_left  = w_eff_len;
                        w_grant_valid = 1'b1;
                        w_grant_idx   = r_ptr;
                        w_state       = ST_BURST;
                    end else begin
                        if (w_found) w_ptr = w_next_ptr;
                        w_fresh = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (bus.beat_accept) begin
                    if (r_beats_left == LEN_WIDTH'(1)) begin
                        w_beats_left  = '0;
                        w_grant_valid = 1'b0;
                        w_state       = ST_IDLE;
                    end else begin
                        w_beats_left = r_beats_left - LEN_WIDTH'(1);
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_fresh       <= 1'b1;
            r_deficit     <= '0;
            r_beats_left  <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            r_state       <= w_state;
            r_ptr         <= w_ptr;
            r_fresh       <= w_fresh;
            r_deficit     <= w_deficit;
            r_beats_left  <= w_beats_left;
            r_grant_valid <= w_grant_valid;
            r_grant_idx   <= w_grant_idx;
        end
    end

    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.beats_left  = r_beats_left;

endmodule
`default_nettype wire
